// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: controller states and digit sizing.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned MAX_NIBBLES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_adder.sv
// Combinational 4-bit ripple adder; also exposes the carry into the MSB for signed overflow.
module nibble_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                c_msb
);

    logic [NIBBLE_W:0] carry;

    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = carry[NIBBLE_W];
    assign c_msb = carry[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder processing one 4-bit digit per cycle with valid/ready handshakes on both sides.
// Optional signed-overflow output ovf is built when OVERFLOW_FLAG_EN is defined.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    input  logic                         cin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  sum,
    output logic                         cout,
`ifdef OVERFLOW_FLAG_EN
    output logic                         ovf,
`endif
    output logic                         busy
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = $clog2(MAX_NIBBLES);

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
    logic                nib_co, nib_cm;
    logic                in_hs, out_hs, last_nib;

    assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    nibble_adder u_nibble_adder (
        .a     (nib_a),
        .b     (nib_b),
        .ci    (carry_q),
        .s     (nib_s),
        .co    (nib_co),
        .c_msb (nib_cm)
    );

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;
`else
    logic unused_cm;
    assign unused_cm = &{1'b0, nib_cm};
`endif

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign last_nib  = (idx_q == IDX_W'(NIBBLES - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef OVERFLOW_FLAG_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE: ;
            RUN: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_s;
                carry_d = nib_co;
                if (last_nib) begin
                    state_d = DONE;
                    cout_d  = nib_co;
                    idx_d   = '0;
`ifdef OVERFLOW_FLAG_EN
                    ovf_d   = nib_cm ^ nib_co;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // in_ready is low in RUN, so this only fires from IDLE or as a DONE->RUN turnaround
        if (in_hs) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder against a plain-arithmetic reference model.
module tb_nibble_serial_adder;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic         clk, rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [W-1:0] a, b, sum;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef OVERFLOW_FLAG_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

`ifdef OVERFLOW_FLAG_EN
    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W-1:0] lo;
        logic [W:0]   full;
        lo   = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, c};
        full = model_add(x, y, c);
        return lo[W-1] ^ full[W];
    endfunction
`endif

    // Handshake one operand set from IDLE, jiggle inputs while running, stop at the first out_valid negedge.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          output int lat, output bit bad_run);
        logic [31:0] r;
        @(negedge clk);
        a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        bad_run = 1'b0;
        while (!out_valid && lat < 64) begin
            if (!busy || in_ready) bad_run = 1'b1;
            r = $urandom;
            in_valid = r[0];
            a = r[31:16];
            b = r[15:0];
            cin = r[1];
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (sum !== '0) begin n_errors++; $display("FAIL reset_sum: got %h expected 0", sum); end
        n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [W-1:0] ta[3] = '{16'h00FF, 16'hFFFF, 16'hFFFF};
        logic [W-1:0] tb[3] = '{16'h0001, 16'h0001, 16'hFFFF};
        logic         tc[3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] es[3] = '{16'h0100, 16'h0000, 16'hFFFF};
        logic         ec[3] = '{1'b0, 1'b1, 1'b1};
        int lat;
        bit bad;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], tc[i], lat, bad);
            n_checks++; if (lat != NIBBLES) begin n_errors++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, NIBBLES); end
            n_checks++; if (sum !== es[i]) begin n_errors++; $display("FAIL basic_sum[%0d]: got %h expected %h", i, sum, es[i]); end
            n_checks++; if (cout !== ec[i]) begin n_errors++; $display("FAIL basic_cout[%0d]: got %b expected %b", i, cout, ec[i]); end
            n_checks++; if (bad) begin n_errors++; $display("FAIL basic_run_flags[%0d]: got busy/in_ready wrong expected busy=1 in_ready=0", i); end
            drain();
            n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drop[%0d]: got out_valid=%b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit bad;
        run_op(16'h1234, 16'h4321, 1'b1, lat, bad);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
            n_checks++; if (sum !== 16'h5556) begin n_errors++; $display("FAIL bp_sum[%0d]: got %h expected 5556", i, sum); end
            n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            @(negedge clk);
        end
        drain();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int unsigned t1, t2;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 16'h0010; b = 16'h0010;
        lat = 0;
        while (!out_valid && lat < 64) begin @(negedge clk); lat++; end
        t1 = cyc;
        n_checks++; if (sum !== 16'h0002) begin n_errors++; $display("FAIL b2b_sum0: got %h expected 0002", sum); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_no_bubble: got busy=%b out_valid=%b expected 1/0", busy, out_valid); end
        lat = 0;
        while (!out_valid && lat < 64) begin @(negedge clk); lat++; end
        t2 = cyc;
        n_checks++; if (t2 - t1 != NIBBLES + 1) begin n_errors++; $display("FAIL b2b_spacing: got %0d expected %0d", t2 - t1, NIBBLES + 1); end
        n_checks++; if (sum !== 16'h0020) begin n_errors++; $display("FAIL b2b_sum1: got %h expected 0020", sum); end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_midrun();
        int lat;
        bit bad;
        bit seen;
        @(negedge clk);
        a = 16'h5A5A; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL midrun_state: got busy=%b out_valid=%b expected 0/0", busy, out_valid); end
        n_checks++; if (sum !== '0 || cout !== 1'b0) begin n_errors++; $display("FAIL midrun_outputs: got sum=%h cout=%b expected 0/0", sum, cout); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (NIBBLES + 2) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_errors++; $display("FAIL midrun_no_result: got out_valid=1 expected 0"); end
        run_op(16'h0003, 16'h0004, 1'b0, lat, bad);
        n_checks++; if (sum !== 16'h0007 || lat != NIBBLES) begin n_errors++; $display("FAIL midrun_next: got sum=%h lat=%0d expected 0007/%0d", sum, lat, NIBBLES); end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [W-1:0] x, y;
        logic         c;
        logic [W:0]   exp;
        int lat;
        bit bad;
        for (int i = 0; i < 25; i++) begin
            r = $urandom; x = r[W-1:0];
            r = $urandom; y = r[W-1:0];
            c = r[W];
            exp = model_add(x, y, c);
            run_op(x, y, c, lat, bad);
            n_checks++; if (sum !== exp[W-1:0] || cout !== exp[W]) begin n_errors++; $display("FAIL rand_result[%0d]: got %b_%h expected %b_%h", i, cout, sum, exp[W], exp[W-1:0]); end
            n_checks++; if (lat != NIBBLES || bad) begin n_errors++; $display("FAIL rand_timing[%0d]: got lat=%0d bad=%0d expected %0d/0", i, lat, bad, NIBBLES); end
`ifdef OVERFLOW_FLAG_EN
            n_checks++; if (ovf !== model_ovf(x, y, c)) begin n_errors++; $display("FAIL rand_ovf[%0d]: got %b expected %b", i, ovf, model_ovf(x, y, c)); end
`endif
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n_checks++; if (sum !== exp[W-1:0] || out_valid !== 1'b1) begin n_errors++; $display("FAIL rand_hold[%0d]: got sum=%h valid=%b expected %h/1", i, sum, out_valid, exp[W-1:0]); end
            drain();
        end
    endtask

`ifdef OVERFLOW_FLAG_EN
    task automatic test_ovf();
        logic [W-1:0] ta[2] = '{16'h7FFF, 16'h8000};
        logic [W-1:0] tb[2] = '{16'h0001, 16'h8000};
        logic [W-1:0] es[2] = '{16'h8000, 16'h0000};
        logic         ec[2] = '{1'b0, 1'b1};
        int lat;
        bit bad;
        for (int i = 0; i < 2; i++) begin
            run_op(ta[i], tb[i], 1'b0, lat, bad);
            n_checks++; if (sum !== es[i] || cout !== ec[i] || ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_case[%0d]: got %h/%b/%b expected %h/%b/1", i, sum, cout, ovf, es[i], ec[i]); end
            drain();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        test_random();
`ifdef OVERFLOW_FLAG_EN
        test_ovf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit digits per operand; operand width W = 4*NIBBLES; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept operands this cycle.
REQ-006 a  input  W  operand A, unsigned, sampled on input handshake.
REQ-007 b  input  W  operand B, unsigned, sampled on input handshake.
REQ-008 cin  input  1  carry-in, sampled on input handshake.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  W  registered sum, stable while out_valid=1.
REQ-012 cout  output  1  registered carry-out of the MSB nibble.
REQ-013 busy  output  1  high in RUN state.

Function
REQ-014 States: IDLE, RUN, DONE; exactly one active at a time.
REQ-015 Input handshake occurs when in_valid=1 and in_ready=1; a, b and cin are captured into internal registers, nibble index is cleared to 0, and the state moves to RUN.
REQ-016 in_ready = 1 in IDLE; in_ready = out_ready in DONE; in_ready = 0 in RUN.
REQ-017 Each RUN cycle adds nibble i of A, nibble i of B and the carry register through one 4-bit adder; the 4-bit result is written to sum bits [4i+3:4i] and the adder carry-out is written to the carry register.
REQ-018 The carry register is loaded with cin on input handshake.
REQ-019 The nibble index increments by 1 per RUN cycle; after nibble NIBBLES-1 the state moves to DONE, and cout takes the final carry.
REQ-020 Latency: out_valid rises exactly NIBBLES cycles after the input handshake edge.
REQ-021 In DONE, out_valid=1; sum and cout hold their values until the output handshake (out_valid=1 and out_ready=1).
REQ-022 On an output handshake without in_valid, the state moves to IDLE and out_valid drops on the next edge.
REQ-023 An output handshake coincident with in_valid=1 is also an input handshake: the new operands are captured and the state moves directly to RUN, with no IDLE bubble.
REQ-024 Arithmetic is modulo 2^W; a carry out of the MSB appears only on cout and never wraps into sum.
REQ-025 in_valid in RUN is ignored; the operand registers are not disturbed.

Reset
REQ-026 While rst_n=0: state=IDLE, out_valid=0, in_ready=1 after release, sum=0, cout=0, busy=0, carry register=0, nibble index=0.
REQ-027 Reset in RUN or DONE discards the operation; no partial result is ever presented.

Configuration
REQ-028 Macro OVERFLOW_FLAG_EN: when defined, an extra output ovf (1 bit) is present. It is registered with cout and equals the two's-complement signed overflow of the MSB nibble add (carry into bit W-1 XOR carry out of bit W-1). It clears on reset.
REQ-029 When OVERFLOW_FLAG_EN is undefined, the ovf port and its logic do not exist; all other behaviour is identical.

Structure
REQ-030 The shared package holds the state enumeration (IDLE, RUN, DONE), the constant NIBBLE_W=4, and the maximum NIBBLES bound.
REQ-031 One sub-module, nibble_adder, is instantiated. It is a combinational 4-bit ripple adder with inputs a[3:0], b[3:0] and ci, and outputs s[3:0] and co, plus a carry-into-MSB output used for ovf.

Verification
REQ-032 Basic add, NIBBLES=4: a=0x00FF, b=0x0001, cin=0 -> after 4 cycles out_valid=1, sum=0x0100, cout=0.
REQ-033 Wrap-around: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-034 Carry-in and backpressure: a=0x1234, b=0x4321, cin=1 with out_ready=0 for 5 cycles -> sum=0x5556 is held stable with out_valid=1 and in_ready=0 until out_ready=1.
REQ-035 Back-to-back operations: in_valid is held high with out_ready=1 for the pairs (0x0001,0x0001) and then (0x0010,0x0010) -> results 0x0002 and 0x0020; consecutive out_valid pulses are NIBBLES+1 cycles apart, with no IDLE cycle between them.
REQ-036 Reset mid-run: rst_n is pulsed low at RUN cycle 2 -> outputs immediately take their reset values, no out_valid appears, and the next operand set 0x0003+0x0004 returns 0x0007.
REQ-037 With OVERFLOW_FLAG_EN: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
